// File: rtl/fru_cfg_loader_if.sv
// Bus between the serial patch-stream source and the FRU config loader.
// The master drives the bitstream. The slave returns the committed config and status.
interface fru_cfg_loader_if #(
  parameter int unsigned CFG_WIDTH = 93
);
  logic                 BitStreamSerialIn;
  logic                 BitStreamValid;
  logic [CFG_WIDTH-1:0] CfgRegFru;
  logic                 CfgValid;
  logic                 CfgUpdate;
  logic                 LoadBusy;
  logic                 LoadErr;
  logic [1:0]           ErrCode;

  modport master (
    output BitStreamSerialIn, BitStreamValid,
    input  CfgRegFru, CfgValid, CfgUpdate, LoadBusy, LoadErr, ErrCode
  );

  modport slave (
    input  BitStreamSerialIn, BitStreamValid,
    output CfgRegFru, CfgValid, CfgUpdate, LoadBusy, LoadErr, ErrCode
  );
endinterface

// File: rtl/fru_cfg_loader.sv
// Serial config front-end for fru: finds the sync word, deserialises the payload and checks its CRC-8.
// A good frame is committed atomically into CfgRegFru. Bad or stalled frames leave the last good config active.
module fru_cfg_loader #(
  parameter int unsigned CFG_WIDTH = 93,
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  fru_cfg_loader_if.slave   bus
);

  localparam int unsigned CNT_W  = ($clog2(CFG_WIDTH) > 3) ? $clog2(CFG_WIDTH) : 3;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    PAYLOAD = 3'd1,
    CRC     = 3'd2,
    CHECK   = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  state_t               state;
  logic [7:0]           win;
  logic [CFG_WIDTH-1:0] shadow;
  logic [7:0]           crc;
  logic [7:0]           rx_crc;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic [7:0]           win_shift_c;
  logic                 timeout_c;

  // CRC-8, poly 0x07, MSB first, no reflection
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign win_shift_c = {win[6:0], bus.BitStreamSerialIn};
  // This idle cycle would be the TIMEOUT-th consecutive one
  assign timeout_c   = (idle_cnt >= IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= HUNT;
      win           <= '0;
      shadow        <= '0;
      crc           <= '0;
      rx_crc        <= '0;
      bit_cnt       <= '0;
      idle_cnt      <= '0;
      bus.CfgRegFru <= '0;
      bus.CfgValid  <= 1'b0;
      bus.CfgUpdate <= 1'b0;
      bus.LoadBusy  <= 1'b0;
      bus.LoadErr   <= 1'b0;
      bus.ErrCode   <= 2'b00;
    end else begin
      bus.CfgUpdate <= 1'b0;
      case (state)
        HUNT: begin
          if (bus.BitStreamValid) begin
            if (win_shift_c == SYNC_WORD) begin
              // Window is cleared so a stale sync pattern cannot re-trigger after an aborted frame
              state        <= PAYLOAD;
              win          <= '0;
              crc          <= '0;
              bit_cnt      <= '0;
              idle_cnt     <= '0;
              bus.LoadErr  <= 1'b0;
              bus.ErrCode  <= 2'b00;
              bus.LoadBusy <= 1'b1;
            end else begin
              win <= win_shift_c;
            end
          end
        end

        PAYLOAD: begin
          if (bus.BitStreamValid) begin
            shadow   <= {shadow[CFG_WIDTH-2:0], bus.BitStreamSerialIn};
            crc      <= crc8_step(crc, bus.BitStreamSerialIn);
            idle_cnt <= '0;
            if (bit_cnt == CNT_W'(CFG_WIDTH - 1)) begin
              state   <= CRC;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (timeout_c) begin
            state        <= HUNT;
            idle_cnt     <= IDLE_W'(TIMEOUT);
            bus.LoadErr  <= 1'b1;
            bus.ErrCode  <= 2'b10;
            bus.LoadBusy <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end

        CRC: begin
          if (bus.BitStreamValid) begin
            rx_crc   <= {rx_crc[6:0], bus.BitStreamSerialIn};
            idle_cnt <= '0;
            if (bit_cnt == CNT_W'(7)) begin
              state        <= CHECK;
              bit_cnt      <= '0;
              bus.LoadBusy <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (timeout_c) begin
            state        <= HUNT;
            idle_cnt     <= IDLE_W'(TIMEOUT);
            bus.LoadErr  <= 1'b1;
            bus.ErrCode  <= 2'b10;
            bus.LoadBusy <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end

        CHECK: begin
          if (rx_crc == crc) begin
            state <= COMMIT;
          end else begin
            state       <= HUNT;
            bus.LoadErr <= 1'b1;
            bus.ErrCode <= 2'b01;
          end
        end

        COMMIT: begin
          state         <= HUNT;
          win           <= '0;
          bus.CfgRegFru <= shadow;
          bus.CfgUpdate <= 1'b1;
          bus.CfgValid  <= 1'b1;
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_fru_cfg_loader.sv
// Bench for fru_cfg_loader: directed frames on an 8-bit instance, randomized frames on the default 93-bit one.
// Frame outcomes are predicted with a polynomial long-division CRC model.
module tb_fru_cfg_loader;

  logic clk;
  logic rst;
  logic ser_bit;
  logic ser_vld;
  logic sel93;

  int checks;
  int errors;

  fru_cfg_loader_if #(.CFG_WIDTH(8))  if8 ();
  fru_cfg_loader_if #(.CFG_WIDTH(93)) if93 ();

  assign if8.BitStreamSerialIn  = ser_bit;
  assign if8.BitStreamValid     = ser_vld & ~sel93;
  assign if93.BitStreamSerialIn = ser_bit;
  assign if93.BitStreamValid    = ser_vld & sel93;

  fru_cfg_loader #(.CFG_WIDTH(8), .SYNC_WORD(8'hA5), .TIMEOUT(64)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  fru_cfg_loader #(.CFG_WIDTH(93), .SYNC_WORD(8'hA5), .TIMEOUT(64)) dut93 (
    .clk (clk),
    .rst (rst),
    .bus (if93.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs of whichever instance is selected
  logic [127:0] o_cfg;
  logic         o_upd, o_valid, o_busy, o_err;
  logic [1:0]   o_code;
  always_comb begin
    o_cfg   = sel93 ? 128'(if93.CfgRegFru) : 128'(if8.CfgRegFru);
    o_upd   = sel93 ? if93.CfgUpdate : if8.CfgUpdate;
    o_valid = sel93 ? if93.CfgValid  : if8.CfgValid;
    o_busy  = sel93 ? if93.LoadBusy  : if8.LoadBusy;
    o_err   = sel93 ? if93.LoadErr   : if8.LoadErr;
    o_code  = sel93 ? if93.ErrCode   : if8.ErrCode;
  end

  int upd_cnt [2];
  always @(negedge clk) begin
    if (if8.CfgUpdate)  upd_cnt[0] = upd_cnt[0] + 1;
    if (if93.CfgUpdate) upd_cnt[1] = upd_cnt[1] + 1;
  end

  logic [127:0] exp_cfg   [2];
  logic         exp_valid [2];
  int           exp_upd   [2];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of payload * x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [127:0] pl, input int w);
    logic [135:0] m;
    m = 136'(pl) << 8;
    for (int i = w + 7; i >= 8; i--)
      if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
    return m[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ser_vld = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_bits(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ser_bit = v[i];
      ser_vld = 1'b1;
      step();
    end
    ser_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [127:0] pl, input int w, input logic [7:0] c,
                            input int gap_at, input int gap_len);
    send_bits(128'(8'hA5), 8);
    check("sync_busy", 128'(o_busy), 128'(1'b1));
    check("sync_err_clr", 128'({o_err, o_code}), 128'(3'b000));
    for (int i = w - 1; i >= 0; i--) begin
      if ((w - 1 - i) == gap_at && gap_len > 0) begin
        idle(gap_len);
        check("gap_busy", 128'(o_busy), 128'(1'b1));
      end
      ser_bit = pl[i];
      ser_vld = 1'b1;
      step();
    end
    send_bits(128'(c), 8);
  endtask

  // Sends one frame and checks the commit or CRC-error outcome predicted by the model
  task automatic frame(input logic [127:0] pl, input int w, input logic [7:0] c,
                       input int gap_at, input int gap_len);
    int d;
    bit ok;
    d  = sel93 ? 1 : 0;
    ok = (ref_crc(pl, w) == c);
    send_frame(pl, w, c, gap_at, gap_len);
    step();
    check("check_upd0", 128'(o_upd), 128'(1'b0));
    check("check_busy0", 128'(o_busy), 128'(1'b0));
    check("check_cfg_hold", o_cfg, exp_cfg[d]);
    step();
    if (ok) begin
      exp_cfg[d]   = pl;
      exp_valid[d] = 1'b1;
      exp_upd[d]   = exp_upd[d] + 1;
      check("commit_upd", 128'(o_upd), 128'(1'b1));
      check("commit_err", 128'(o_err), 128'(1'b0));
    end else begin
      check("crc_err", 128'({o_err, o_code}), 128'(3'b101));
      check("crc_no_upd", 128'(o_upd), 128'(1'b0));
    end
    check("cfg", o_cfg, exp_cfg[d]);
    check("cfg_valid", 128'(o_valid), 128'(exp_valid[d]));
    step();
    check("upd_drop", 128'(o_upd), 128'(1'b0));
    check("upd_count", 128'(upd_cnt[d]), 128'(exp_upd[d]));
    idle(2);
  endtask

  initial begin
    logic [127:0] pl;
    logic [127:0] pl_sent;
    logic [7:0]   c;
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    ser_bit = 1'b0;
    ser_vld = 1'b0;
    sel93   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_cfg[k]   = '0;
      exp_valid[k] = 1'b0;
      exp_upd[k]   = 0;
      upd_cnt[k]   = 0;
    end

    // Reset state
    repeat (3) step();
    check("rst_cfg", o_cfg, 128'(0));
    check("rst_flags", 128'({o_valid, o_upd, o_busy, o_err, o_code}), 128'(0));
    rst = 1'b1;
    idle(2);

    // Basic commit, then a good and a bad frame
    frame(128'(8'h01), 8, 8'h07, -1, 0);
    frame(128'(8'hFF), 8, 8'hF3, -1, 0);
    frame(128'(8'h00), 8, 8'h55, -1, 0);

    // Noise must not sync; the error from the previous frame persists until the next sync
    send_bits(128'(16'h3C5A), 16);
    check("noise_no_sync", 128'(o_busy), 128'(1'b0));
    check("noise_err_kept", 128'({o_err, o_code}), 128'(3'b101));
    idle(2);
    frame(128'(8'h01), 8, 8'h07, -1, 0);

    // Mid-payload gap shorter than the timeout
    pl = 128'($urandom_range(0, 255));
    frame(pl, 8, ref_crc(pl, 8), 3, 10);

    // Gap of exactly TIMEOUT cycles aborts the frame
    send_bits(128'(8'hA5), 8);
    send_bits(128'(3'b101), 3);
    idle(63);
    check("to_busy_63", 128'(o_busy), 128'(1'b1));
    check("to_err_63", 128'(o_err), 128'(1'b0));
    idle(1);
    check("to_busy_64", 128'(o_busy), 128'(1'b0));
    check("to_err_64", 128'({o_err, o_code}), 128'(3'b110));
    check("to_cfg_hold", o_cfg, exp_cfg[0]);
    idle(2);
    check("to_no_upd", 128'(upd_cnt[0]), 128'(exp_upd[0]));

    // Reset during payload bit 4 discards the frame and clears outputs
    send_bits(128'(8'hA5), 8);
    send_bits(128'(4'hA), 4);
    ser_bit = 1'b1;
    ser_vld = 1'b1;
    rst     = 1'b0;
    step();
    ser_vld = 1'b0;
    rst     = 1'b1;
    check("mid_rst_cfg", o_cfg, 128'(0));
    check("mid_rst_flags", 128'({o_valid, o_upd, o_busy, o_err, o_code}), 128'(0));
    exp_cfg[0]   = '0;
    exp_valid[0] = 1'b0;
    exp_cfg[1]   = '0;
    exp_valid[1] = 1'b0;
    idle(2);
    pl = 128'($urandom_range(0, 255));
    frame(pl, 8, ref_crc(pl, 8), -1, 0);

    // Default width: random payloads, random gaps, some with a flipped payload bit
    sel93 = 1'b1;
    idle(2);
    for (int it = 0; it < 8; it++) begin
      pl      = 128'(93'({$urandom(), $urandom(), $urandom()}));
      c       = ref_crc(pl, 93);
      pl_sent = pl;
      if (it == 1 || (it > 1 && $urandom_range(0, 1) == 1))
        pl_sent = pl ^ (128'(1) << $urandom_range(0, 92));
      if (it < 2)
        frame(pl_sent, 93, c, -1, 0);
      else
        frame(pl_sent, 93, c, int'($urandom_range(0, 92)), int'($urandom_range(0, 40)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
